// File: rtl/gcd_controller.sv
// Control FSM for a 16-bit subtractive GCD datapath: fetches two operands over a
// valid/req handshake, then steers the subtractor until A==B or the iteration limit hits.
module gcd_controller #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic             op_req,
  output logic             LdA,
  output logic             LdB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timeout;

  // Timeout outranks a simultaneous eq only when the operands have not converged.
  assign timeout = (cnt_q == MAX_CNT) && !eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        LOAD_A: begin
          if (op_valid) state_q <= LOAD_B;
        end
        LOAD_B: begin
          if (op_valid) state_q <= COMPUTE;
        end
        COMPUTE: begin
          if (timeout) begin
            state_q <= DONE;
            err_q   <= 1'b1;
          end else if (eq) begin
            state_q <= DONE;
          end else begin
            // Counts even with no flag set so a broken datapath still times out.
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    op_req = 1'b0;
    LdA    = 1'b0;
    LdB    = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    sel_in = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state_q)
      LOAD_A: begin
        op_req = 1'b1;
        sel_in = 1'b1;
        busy   = 1'b1;
        LdA    = op_valid;
      end
      LOAD_B: begin
        op_req = 1'b1;
        sel_in = 1'b1;
        busy   = 1'b1;
        LdB    = op_valid;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (!timeout && !eq) begin
          if (gt) begin
            sel2 = 1'b1;
            LdA  = 1'b1;
          end else if (lt) begin
            sel1 = 1'b1;
            LdB  = 1'b1;
          end
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Randomized bench for gcd_controller: a small datapath closes the loop, and a
// transaction-level Euclid model predicts every cycle's outputs.
module tb_gcd_controller;
  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 8;

  logic clk = 1'b0;
  logic rst, start, op_valid, gt, eq, lt;
  logic op_req, LdA, LdB, sel1, sel2, sel_in, busy, done, err;
  logic [CNT_W-1:0] iter_cnt;

  always #5 clk = ~clk;

  gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .op_valid(op_valid),
    .gt(gt), .eq(eq), .lt(lt),
    .op_req(op_req), .LdA(LdA), .LdB(LdB), .sel1(sel1), .sel2(sel2),
    .sel_in(sel_in), .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
  );

  // Datapath the controller steers; kill forces all compare flags low.
  logic [15:0] a_reg = 16'd0, b_reg = 16'd0, data_in, x_mux, y_mux, bus;
  logic kill;
  assign x_mux = sel1 ? b_reg : a_reg;
  assign y_mux = sel2 ? b_reg : a_reg;
  assign bus   = sel_in ? data_in : (x_mux - y_mux);
  assign gt    = !kill && (a_reg > b_reg);
  assign eq    = !kill && (a_reg == b_reg);
  assign lt    = !kill && (a_reg < b_reg);
  always @(posedge clk) begin
    if (LdA) a_reg <= bus;
    if (LdB) b_reg <= bus;
  end

  typedef struct packed {
    logic e_req, e_lda, e_ldb, e_selin, e_busy, e_done, e_err;
    logic chk_sel, e_sel1, e_sel2;
    logic [CNT_W-1:0] e_iter;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  int checks = 0, failures = 0;
  int cyc = 0, done_cyc = -1, ldb_pulses = 0;
  logic [CNT_W-1:0] last_iter;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, req);
    end
  endtask

  function automatic exp_t mk(input logic rq, la, lb, si, bs, dn, er, input logic [CNT_W-1:0] it);
    exp_t e;
    e = '0;
    e.e_req = rq; e.e_lda = la; e.e_ldb = lb; e.e_selin = si;
    e.e_busy = bs; e.e_done = dn; e.e_err = er; e.e_iter = it;
    return e;
  endfunction

  // Single compare process: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) done_cyc = cyc;
    if (LdB === 1'b1 && sel_in === 1'b0 && busy === 1'b1) ldb_pulses++;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      chk("op_req", 32'(op_req), 32'(cmp_e.e_req));
      chk("LdA", 32'(LdA), 32'(cmp_e.e_lda));
      chk("LdB", 32'(LdB), 32'(cmp_e.e_ldb));
      chk("sel_in", 32'(sel_in), 32'(cmp_e.e_selin));
      chk("busy", 32'(busy), 32'(cmp_e.e_busy));
      chk("done", 32'(done), 32'(cmp_e.e_done));
      chk("err", 32'(err), 32'(cmp_e.e_err));
      chk("iter_cnt", 32'(iter_cnt), 32'(cmp_e.e_iter));
      if (cmp_e.chk_sel) begin
        chk("sel1", 32'(sel1), 32'(cmp_e.e_sel1));
        chk("sel2", 32'(sel2), 32'(cmp_e.e_sel2));
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic v, input logic [15:0] d,
                      input exp_t e, input bit push);
    @(posedge clk); #1;
    rst = r; start = s; op_valid = v; data_in = d;
    if (push) exp_q.push_back(e);
  endtask

  // Behavioural model: Euclid by subtraction with an iteration budget, one decision per cycle.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int sa, input int sb,
                         input bit k, input int abort,
                         output int lat, output int nsub, output bit terr);
    exp_t e;
    logic [15:0] ma, mb;
    int cnt, s_cyc;
    bit aborted;
    ma = a; mb = b; cnt = 0; terr = 1'b0; aborted = 1'b0; lat = -1;
    for (int g = 0; g < int'($urandom_range(0, 2)); g++)
      step(0, 0, 0, 16'(0), mk(0, 0, 0, 0, 0, 0, 0, last_iter), 1);
    step(0, 1, 0, 16'(0), mk(0, 0, 0, 0, 0, 0, 0, last_iter), 1);
    s_cyc = cyc + 1;
    ldb_pulses = 0;
    for (int i = 0; i <= sa; i++)
      step(0, 1'($urandom_range(0, 1)), (i == sa), (i == sa) ? a : 16'($urandom),
           mk(1, (i == sa), 0, 1, 1, 0, 0, '0), 1);
    for (int i = 0; i <= sb; i++)
      step(0, 1'($urandom_range(0, 1)), (i == sb), (i == sb) ? b : 16'($urandom),
           mk(1, 0, (i == sb), 1, 1, 0, 0, '0), 1);
    kill = k;
    for (int i = 0; i <= MAX_ITER + 1; i++) begin
      e = mk(0, 0, 0, 0, 1, 0, 0, CNT_W'(cnt));
      if (i == abort) begin
        step(1, 0, 0, 16'(0), e, 0);
        kill = 1'b0;
        step(0, 0, 0, 16'(0), mk(0, 0, 0, 0, 0, 0, 0, '0), 1);
        last_iter = '0;
        aborted = 1'b1;
        break;
      end
      if (!k && ma == mb) begin
        step(0, 1'($urandom_range(0, 1)), 0, 16'(0), e, 1);
        break;
      end else if (cnt == MAX_ITER) begin
        terr = 1'b1;
        step(0, 1'($urandom_range(0, 1)), 0, 16'(0), e, 1);
        break;
      end else if (!k && ma > mb) begin
        e.e_lda = 1'b1; e.chk_sel = 1'b1; e.e_sel1 = 1'b0; e.e_sel2 = 1'b1;
        step(0, 1'($urandom_range(0, 1)), 0, 16'(0), e, 1);
        ma = ma - mb; cnt++;
      end else if (!k && ma < mb) begin
        e.e_ldb = 1'b1; e.chk_sel = 1'b1; e.e_sel1 = 1'b1; e.e_sel2 = 1'b0;
        step(0, 1'($urandom_range(0, 1)), 0, 16'(0), e, 1);
        mb = mb - ma; cnt++;
      end else begin
        step(0, 1'($urandom_range(0, 1)), 0, 16'(0), e, 1);
        cnt++;
      end
    end
    kill = 1'b0;
    nsub = cnt;
    if (!aborted) begin
      step(0, 1'($urandom_range(0, 1)), 0, 16'(0), mk(0, 0, 0, 0, 1, 1, terr, CNT_W'(cnt)), 1);
      last_iter = CNT_W'(cnt);
      step(0, 0, 0, 16'(0), mk(0, 0, 0, 0, 0, 0, 0, CNT_W'(cnt)), 1);
      lat = done_cyc - s_cyc;
    end
  endtask

  int lat, ns;
  bit te;

  initial begin
    rst = 1'b1; start = 1'b0; op_valid = 1'b0; data_in = 16'd0; kill = 1'b0; last_iter = '0;
    step(1, 0, 0, 16'(0), '0, 0);
    step(1, 0, 0, 16'(0), '0, 0);
    step(0, 0, 0, 16'(0), mk(0, 0, 0, 0, 0, 0, 0, '0), 1);

    run_txn(16'd48, 16'd18, 0, 0, 0, -1, lat, ns, te);
    chk("lat_48_18", 32'(lat), 32'd8);
    chk("nsub_48_18", 32'(ns), 32'd4);
    chk("a_48_18", 32'(a_reg), 32'd6);
    chk("b_48_18", 32'(b_reg), 32'd6);
    chk("iter_held_48_18", 32'(iter_cnt), 32'd4);
    chk("err_flag_48_18", 32'(te), 32'd0);

    run_txn(16'd7, 16'd7, 0, 0, 0, -1, lat, ns, te);
    chk("lat_7_7", 32'(lat), 32'd4);
    chk("nsub_7_7", 32'(ns), 32'd0);
    chk("ldb_7_7", 32'(ldb_pulses), 32'd0);

    run_txn(16'd0, 16'd5, 0, 0, 0, -1, lat, ns, te);
    chk("timeout_0_5", 32'(te), 32'd1);
    chk("nsub_0_5", 32'(ns), 32'd8);
    chk("ldb_pulses_0_5", 32'(ldb_pulses), 32'd8);
    chk("iter_held_0_5", 32'(iter_cnt), 32'd8);

    run_txn(16'd48, 16'd18, 3, 2, 0, -1, lat, ns, te);
    chk("lat_stall", 32'(lat), 32'd13);

    run_txn(16'd9, 16'd4, 0, 0, 1, -1, lat, ns, te);
    chk("timeout_noflag", 32'(te), 32'd1);
    chk("nsub_noflag", 32'(ns), 32'd8);

    run_txn(16'd48, 16'd18, 0, 0, 0, 2, lat, ns, te);
    chk("abort_iter", 32'(iter_cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] ra, rb;
      int ab;
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, ab, lat, ns, te);
    end

    step(0, 0, 0, 16'(0), '0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
